// File: rtl/xres_decode.sv
// rtl/xres_decode.sv - signed result to sign+BCD converter with multiplexed 7-segment display driver
module xres_decode #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [10:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [15:0] bcd,
    output logic [4:0]  an,
    output logic [7:0]  cat
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [10:0]   mag_q, mag_d;
    logic [15:0]   work_q, work_d;
    logic [3:0]    iter_q, iter_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          neg_q, neg_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [15:0]   adj;

    // Active-low segment pattern for one decimal digit; codes above 9 never occur.
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Conversion FSM next state: latch |data_in|, eleven add-3/shift steps, then publish.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        work_d  = work_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        bcd_d   = bcd_q;

        adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    sign_d = data_in[10];
                    // 11-bit unsigned is wide enough for |-1024| = 1024.
                    mag_d  = data_in[10] ? (~data_in + 11'd1) : data_in;
                    work_d = 16'h0000;
                    iter_d = 4'd11;
                    busy_d = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {work_d, mag_d} = {adj[14:0], mag_q, 1'b0};
                iter_d = iter_q - 4'd1;
                if (iter_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = work_q;
                neg_d   = sign_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Refresh divider: hold each display position for SCAN_DIV clocks, cycle 0..4.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Display decode from registered scan index and the last published result.
    always_comb begin
        logic blank3;
        logic blank2;
        logic blank1;
        blank3 = (BLANK_LEADING != 0) && (bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (bcd_q[7:4] == 4'd0);
        an  = ~(5'b00001 << idx_q);
        case (idx_q)
            3'd4:    cat = neg_q ? SEG_MINUS : SEG_BLANK;
            3'd3:    cat = blank3 ? SEG_BLANK : seg_of(bcd_q[15:12]);
            3'd2:    cat = blank2 ? SEG_BLANK : seg_of(bcd_q[11:8]);
            3'd1:    cat = blank1 ? SEG_BLANK : seg_of(bcd_q[7:4]);
            3'd0:    cat = seg_of(bcd_q[3:0]);
            default: cat = SEG_BLANK;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign neg  = neg_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_xres_decode.sv
// tb/tb_xres_decode.sv - self-checking bench for xres_decode
module tb_xres_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [10:0] data_in;

    logic        busy0, done0, neg0;
    logic [15:0] bcd0;
    logic [4:0]  an0;
    logic [7:0]  cat0;
    logic        busy1, done1, neg1;
    logic [15:0] bcd1;
    logic [4:0]  an1;
    logic [7:0]  cat1;

    xres_decode #(.SCAN_DIV(4), .BLANK_LEADING(1)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .data_in(data_in),
        .busy(busy0), .done(done0), .neg(neg0), .bcd(bcd0), .an(an0), .cat(cat0)
    );

    xres_decode #(.SCAN_DIV(3), .BLANK_LEADING(0)) dut1 (
        .clk(clk), .rst(rst), .sel(sel), .data_in(data_in),
        .busy(busy1), .done(done1), .neg(neg1), .bcd(bcd1), .an(an1), .cat(cat1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cur_mag = 0;
    bit cur_neg = 1'b0;

    typedef struct {
        logic [10:0] din;
        logic [15:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int value_of(input logic [10:0] d);
        return d[10] ? int'(d) - 2048 : int'(d);
    endfunction

    function automatic int mag_of(input logic [10:0] d);
        int v;
        v = value_of(d);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] model_bcd(input int m);
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [7:0] seg_ref(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Position 4 = sign, 3..0 = thousands..units; blank if the shown number has fewer digits.
    function automatic logic [7:0] model_cat(input int pos, input int m, input bit ng, input bit bl);
        int pw;
        if (pos == 4) return ng ? 8'hBF : 8'hFF;
        pw = 1;
        for (int i = 0; i < pos; i++) pw = pw * 10;
        if (pos != 0 && bl && m < pw) return 8'hFF;
        return seg_ref((m / pw) % 10);
    endfunction

    function automatic int pos_of(input logic [4:0] a);
        for (int i = 0; i < 5; i++) if (a[i] == 1'b0) return i;
        return 0;
    endfunction

    task automatic check_display(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk("an0_onehot", $countones(~an0), 1);
            chk("cat0", cat0, model_cat(pos_of(an0), cur_mag, cur_neg, 1'b1));
            chk("an1_onehot", $countones(~an1), 1);
            chk("cat1", cat1, model_cat(pos_of(an1), cur_mag, cur_neg, 1'b0));
            tick();
        end
    endtask

    // Pulse sel and follow the conversion to done; returns at the sample where done is high.
    task automatic convert(input logic [10:0] d, input logic [15:0] eb, input logic en);
        int n;
        sel = 1'b1;
        data_in = d;
        tick();
        sel = 1'b0;
        chk("busy_start", busy0, 1);
        n = 0;
        while (done0 !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (done0 !== 1'b1) chk("busy_hold", busy0, 1);
        end
        chk("latency", n, 12);
        chk("busy_end", busy0, 0);
        chk("bcd0", bcd0, eb);
        chk("neg0", neg0, en);
        chk("bcd1", bcd1, eb);
        chk("neg1", neg1, en);
        cur_mag = mag_of(d);
        cur_neg = value_of(d) < 0;
    endtask

    initial begin
        logic [4:0] ea;
        int nd;
        logic [10:0] d;

        vecs[0] = '{11'h000, 16'h0000, 1'b0};
        vecs[1] = '{11'd999, 16'h0999, 1'b0};
        vecs[2] = '{11'h7FF, 16'h0001, 1'b1};
        vecs[3] = '{11'h400, 16'h1024, 1'b1};
        vecs[4] = '{11'd1023, 16'h1023, 1'b0};
        vecs[5] = '{11'd7, 16'h0007, 1'b0};

        rst = 1'b1;
        sel = 1'b0;
        data_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_neg", neg0, 0);
        chk("rst_bcd", bcd0, 16'h0000);
        chk("rst_an", an0, 5'b11110);
        chk("rst_cat", cat0, 8'hC0);

        for (int k = 0; k < 24; k++) begin
            ea = ~(5'b00001 << ((k / 4) % 5));
            chk("scan_an0", an0, ea);
            chk("scan_cat0", cat0, model_cat((k / 4) % 5, 0, 1'b0, 1'b1));
            ea = ~(5'b00001 << ((k / 3) % 5));
            chk("scan_an1", an1, ea);
            tick();
        end

        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].din, vecs[i].exp_bcd, vecs[i].exp_neg);
            tick();
            chk("done_pulse", done0, 0);
            check_display(16);
        end

        convert(11'h400, 16'h1024, 1'b1);
        convert(11'd1023, 16'h1023, 1'b0);
        tick();
        chk("done_pulse_b2b", done0, 0);

        // Second sel during SHIFT must be ignored.
        sel = 1'b1;
        data_in = 11'd5;
        tick();
        sel = 1'b0;
        repeat (4) tick();
        sel = 1'b1;
        data_in = 11'd7;
        tick();
        sel = 1'b0;
        nd = 0;
        repeat (15) begin
            tick();
            if (done0 === 1'b1) nd++;
        end
        chk("ignore_sel_dones", nd, 1);
        chk("ignore_sel_bcd", bcd0, 16'h0005);
        chk("ignore_sel_neg", neg0, 0);
        cur_mag = 5;
        cur_neg = 1'b0;

        // Reset in the middle of a conversion aborts it.
        sel = 1'b1;
        data_in = 11'h7F7;
        tick();
        sel = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_bcd", bcd0, 16'h0000);
        chk("abort_neg", neg0, 0);
        chk("abort_an", an0, 5'b11110);
        nd = 0;
        repeat (15) begin
            tick();
            if (done0 === 1'b1) nd++;
        end
        chk("abort_dones", nd, 0);
        chk("abort_bcd_hold", bcd0, 16'h0000);
        cur_mag = 0;
        cur_neg = 1'b0;

        for (int i = 0; i < 40; i++) begin
            d = 11'($urandom_range(0, 2047));
            convert(d, model_bcd(mag_of(d)), value_of(d) < 0);
            tick();
            if (i % 8 == 0) check_display(15);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
